mem_rd_arbiter: RTL
===================

// Module: mem_rd_arbiter
// PURPOSE
//  Shares one memory-controller read port between 4 video read channels (quad display: one vout_pro per quadrant).
//  Each channel speaks the controller's read-burst handshake; the arbiter grants one burst at a time, round-robin.
//  Single clock domain (mem_clk); sits between the 4 frame-buffer readers and the DDR controller.
// PARAMETERS
//  MEM_DATA_BITS  64  controller data width
//  ADDR_BITS      24  burst address width
//  LEN_BITS       10  burst length width
// PORTS
//  mem_clk              in   1              memory clock, all logic rising-edge
//  rst_n                in   1              asynchronous active-low reset
//  ch_rd_burst_req      in   4              per-channel read request, bit i = channel i
//  ch_rd_burst_len      in   4*LEN_BITS     {ch3,ch2,ch1,ch0} burst lengths
//  ch_rd_burst_addr     in   4*ADDR_BITS    {ch3,ch2,ch1,ch0} start addresses
//  ch_rd_burst_data_valid out 4             data-valid routed to granted channel only
//  ch_rd_burst_data     out  MEM_DATA_BITS  controller read data, broadcast to all channels
//  ch_burst_finish      out  4              burst-done pulse routed to granted channel only
//  rd_burst_req         out  1              request to controller
//  rd_burst_len         out  LEN_BITS       latched length of granted burst
//  rd_burst_addr        out  ADDR_BITS      latched address of granted burst
//  rd_burst_data_valid  in   1              controller data valid
//  rd_burst_data        in   MEM_DATA_BITS  controller data
//  burst_finish         in   1              controller burst complete
//  grant_id             out  2              currently/last granted channel
//  busy                 out  1              1 when state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, rd_burst_req=0, rd_burst_len=0, rd_burst_addr=0, grant_id=0, last_ptr=3
//   (ch0 wins first), busy=0, ch_* outputs 0. Reset mid-burst aborts immediately, no finish pulse.
//  FSM states: IDLE, ISSUE, BURST, RELEASE.
//  IDLE: if |ch_rd_burst_req, pick first set bit scanning last_ptr+1, +2, +3, +4 (mod 4);
//   register grant_id, len, addr of winner; go ISSUE. No request -> stay.
//  ISSUE (1 cycle): if latched len==0 -> local completion: ch_burst_finish[grant_id]=1 this cycle,
//   rd_burst_req stays 0, go RELEASE. Else assert rd_burst_req, go BURST.
//  BURST: rd_burst_req held 1 until burst_finish sampled 1 (level-held request, controller style);
//   rd_burst_len/addr stable throughout.
//   ch_rd_burst_data_valid[grant_id] = rd_burst_data_valid (combinational, 0 latency); other bits 0.
//   ch_burst_finish[grant_id] = burst_finish (combinational); rd_burst_req drops next edge; go RELEASE.
//  RELEASE (1 cycle): last_ptr<=grant_id; no grant issued, lets requester drop its req; go IDLE.
//  Grant-to-grant minimum spacing: burst_finish edge + 2 cycles (RELEASE, IDLE) before next ISSUE.
//  ch_rd_burst_data = rd_burst_data always (unregistered broadcast).
//  rd_burst_data_valid / burst_finish outside BURST: ignored, never routed to any channel.
//  Requester deasserting req during ISSUE/BURST: burst still runs to completion (no abort).
//  Requests arriving during a burst wait; round-robin guarantees each active channel one burst
//   per 4 grants (no starvation).
//  len/addr sampled only at IDLE->ISSUE; changes afterwards have no effect on current burst.
// TESTING
//  1. ch1 only, len=128, addr=0x001000: rd_burst_req rises 2 cycles after req, addr/len match;
//     128 valids appear only on ch_rd_burst_data_valid[1]; finish pulses on bit1 only.
//  2. all 4 req held high, len=16: grant order 0,1,2,3,0,1...; grant_id matches each burst.
//  3. ch0 and ch2 continuous, ch1/ch3 idle: alternation 0,2,0,2; no channel granted twice in a row.
//  4. ch3 req with len=0: ch_burst_finish[3] one-cycle pulse in ISSUE, rd_burst_req never asserts.
//  5. stray rd_burst_data_valid and burst_finish pulses while IDLE: all ch_* outputs remain 0.
//  6. rst_n low mid-burst (ch2, 40 of 64 words): all outputs 0 asynchronously; after release
//     with ch2 and ch0 requesting, ch0 granted first (last_ptr=3).

Source files
------------

// File: rtl/mem_rd_arbiter.sv
// Round-robin arbiter that shares one DDR controller read-burst port between four video read channels.
// One burst is granted at a time. Data and finish are routed only to the granted channel.
module mem_rd_arbiter #(
    parameter int MEM_DATA_BITS = 64,
    parameter int ADDR_BITS     = 24,
    parameter int LEN_BITS      = 10
) (
    input  logic                     mem_clk,
    input  logic                     rst_n,
    input  logic [3:0]               ch_rd_burst_req,
    input  logic [4*LEN_BITS-1:0]    ch_rd_burst_len,
    input  logic [4*ADDR_BITS-1:0]   ch_rd_burst_addr,
    output logic [3:0]               ch_rd_burst_data_valid,
    output logic [MEM_DATA_BITS-1:0] ch_rd_burst_data,
    output logic [3:0]               ch_burst_finish,
    output logic                     rd_burst_req,
    output logic [LEN_BITS-1:0]      rd_burst_len,
    output logic [ADDR_BITS-1:0]     rd_burst_addr,
    input  logic                     rd_burst_data_valid,
    input  logic [MEM_DATA_BITS-1:0] rd_burst_data,
    input  logic                     burst_finish,
    output logic [1:0]               grant_id,
    output logic                     busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_BURST   = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [1:0]            r_grant;
    logic [1:0]            r_last_ptr;
    logic [LEN_BITS-1:0]   r_len;
    logic [ADDR_BITS-1:0]  r_addr;
    logic                  r_req;
    logic                  r_busy;
    logic [2:0]            w_pick;
    logic                  w_found;
    logic [1:0]            w_win;
    logic                  w_len_zero;

    // Returns {found, id}: the first requester scanning last+1 .. last+4 (mod 4).
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
        logic       found;
        logic [1:0] id;
        logic [1:0] idx;
        found = 1'b0;
        id    = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (!found && req[idx]) begin
                found = 1'b1;
                id    = idx;
            end else begin
                found = found;
            end
        end
        return {found, id};
    endfunction

    assign w_pick     = rr_pick(ch_rd_burst_req, r_last_ptr);
    assign w_found    = w_pick[2];
    assign w_win      = w_pick[1:0];
    assign w_len_zero = (r_len == {LEN_BITS{1'b0}});

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_found) w_next = S_ISSUE;
                else         w_next = S_IDLE;
            end
            S_ISSUE: begin
                if (w_len_zero) w_next = S_RELEASE;
                else            w_next = S_BURST;
            end
            S_BURST: begin
                if (burst_finish) w_next = S_RELEASE;
                else              w_next = S_BURST;
            end
            S_RELEASE: w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Route controller valid/finish to the granted channel only. A zero-length burst completes locally.
    always_comb begin
        ch_rd_burst_data_valid = 4'b0000;
        ch_burst_finish        = 4'b0000;
        case (r_state)
            S_ISSUE: begin
                if (w_len_zero) ch_burst_finish[r_grant] = 1'b1;
                else            ch_burst_finish          = 4'b0000;
            end
            S_BURST: begin
                ch_rd_burst_data_valid[r_grant] = rd_burst_data_valid;
                ch_burst_finish[r_grant]        = burst_finish;
            end
            default: begin
                ch_rd_burst_data_valid = 4'b0000;
                ch_burst_finish        = 4'b0000;
            end
        endcase
    end

    // State, grant latch and level-held controller request.
    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_grant    <= 2'd0;
            r_last_ptr <= 2'd3;
            r_len      <= {LEN_BITS{1'b0}};
            r_addr     <= {ADDR_BITS{1'b0}};
            r_req      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant <= w_win;
                        r_len   <= ch_rd_burst_len[w_win*LEN_BITS +: LEN_BITS];
                        r_addr  <= ch_rd_burst_addr[w_win*ADDR_BITS +: ADDR_BITS];
                    end else begin
                        r_grant <= r_grant;
                    end
                end
                S_ISSUE:   r_req <= !w_len_zero;
                S_BURST: begin
                    if (burst_finish) r_req <= 1'b0;
                    else              r_req <= 1'b1;
                end
                S_RELEASE: r_last_ptr <= r_grant;
                default:   r_req <= 1'b0;
            endcase
        end
    end

    assign ch_rd_burst_data = rd_burst_data;
    assign rd_burst_req     = r_req;
    assign rd_burst_len     = r_len;
    assign rd_burst_addr    = r_addr;
    assign grant_id         = r_grant;
    assign busy             = r_busy;

endmodule
